input_repeat_engine: RTL

- Parametrised successor to the fixed 7-button input manager: N_CH independent channels, each with a runtime-selectable mode (off / one-shot / DAS / fast-repeat).
- Converts debounced raw button levels into single-cycle command pulses, timed in game frames (tick_game).
- Sits between the keyboard/controller decoder and the game FSM; channel order is fixed by the shared package.

---
 rtl/input_pkg.sv | 39 +++
 rtl/input_repeat_channel.sv | 132 +++++++++++++
 rtl/input_repeat_engine.sv | 76 +++++++
 3 files changed

// File: rtl/input_pkg.sv
`default_nettype none
// ============================================================================
// Module      : input_pkg
// Description : Shared types and constants for the input repeat engine.
// Revision    : 1.0 - initial release
// ============================================================================
package input_pkg;

    typedef enum logic [1:0] {
        IM_OFF     = 2'd0,
        IM_ONESHOT = 2'd1,
        IM_DAS     = 2'd2,
        IM_FAST    = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        CS_IDLE   = 3'd0,
        CS_HOLD   = 3'd1,
        CS_DELAY  = 3'd2,
        CS_REPEAT = 3'd3
`ifdef INPUT_REPEAT_OPPOSE_EN
        ,
        CS_SUPPRESSED = 3'd4
`endif
    } ch_state_e;

    localparam int CH_LEFT    = 0;
    localparam int CH_RIGHT   = 1;
    localparam int CH_DOWN    = 2;
    localparam int CH_ROT_CW  = 3;
    localparam int CH_ROT_CCW = 4;
    localparam int CH_DROP    = 5;
    localparam int CH_HOLD    = 6;

    localparam int DAS_DEFAULT = 16;
    localparam int ARR_DEFAULT = 6;

endpackage
`default_nettype wire

// File: rtl/input_repeat_channel.sv
`default_nettype none
// ============================================================================
// Module      : input_repeat_channel
// Description : One input channel: press-edge detect, mode FSM, frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module input_repeat_channel
    import input_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             raw,
    input  mode_e            mode,
    input  logic [CNT_W-1:0] das,
    input  logic [CNT_W-1:0] arr,
    input  logic [CNT_W-1:0] fast,
`ifdef INPUT_REPEAT_OPPOSE_EN
    input  logic             suppress,
    input  logic             restart,
`endif
    output logic             cmd,
    output logic             held
);

    ch_state_e        r_state, w_state_nx;
    mode_e            r_mode, w_mode_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic             r_prev, r_armed, r_cmd, r_held;
    logic             w_edge, w_pulse;
    logic [CNT_W-1:0] w_inc, w_das_eff, w_per_eff, w_per_raw;
    ch_state_e        w_entry_state;

    // r_armed stays low after reset until the button is seen released
    assign w_edge    = raw & ~r_prev & r_armed & (mode != IM_OFF);
    assign w_inc     = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_das_eff = (das == '0) ? CNT_W'(1) : das;
    assign w_per_raw = (r_mode == IM_DAS) ? arr : fast;
    assign w_per_eff = (w_per_raw == '0) ? CNT_W'(1) : w_per_raw;

    always_comb begin
        w_entry_state = CS_IDLE;
        case (mode)
            IM_ONESHOT: w_entry_state = CS_HOLD;
            IM_DAS:     w_entry_state = CS_DELAY;
            IM_FAST:    w_entry_state = CS_REPEAT;
            default:    w_entry_state = CS_IDLE;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_mode_nx  = r_mode;
        w_pulse    = 1'b0;
        if (!raw) begin
            w_state_nx = CS_IDLE;
            w_cnt_nx   = '0;
        end else if (r_state != CS_IDLE && mode != r_mode) begin
            // prev stays high, so no new press is seen until release
            w_state_nx = CS_IDLE;
            w_cnt_nx   = '0;
`ifdef INPUT_REPEAT_OPPOSE_EN
        end else if (suppress && (r_state != CS_IDLE || w_edge)) begin
            w_state_nx = CS_SUPPRESSED;
            w_cnt_nx   = '0;
            w_mode_nx  = mode;
`endif
        end else if (w_edge) begin
            w_pulse    = 1'b1;
            w_cnt_nx   = '0;
            w_mode_nx  = mode;
            w_state_nx = w_entry_state;
`ifdef INPUT_REPEAT_OPPOSE_EN
        end else if (r_state == CS_SUPPRESSED) begin
            // resume the held mode from its start, without a press pulse
            if (restart) begin
                w_state_nx = w_entry_state;
                w_cnt_nx   = '0;
            end
`endif
        end else if (tick) begin
            case (r_state)
                CS_DELAY: begin
                    if (w_inc == w_das_eff) begin
                        w_pulse    = 1'b1;
                        w_cnt_nx   = '0;
                        w_state_nx = CS_REPEAT;
                    end else begin
                        w_cnt_nx = w_inc;
                    end
                end
                CS_REPEAT: begin
                    if (w_inc == w_per_eff) begin
                        w_pulse  = 1'b1;
                        w_cnt_nx = '0;
                    end else begin
                        w_cnt_nx = w_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CS_IDLE;
            r_mode  <= IM_OFF;
            r_cnt   <= '0;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_cmd   <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_mode  <= w_mode_nx;
            r_cnt   <= w_cnt_nx;
            r_prev  <= raw;
            r_armed <= r_armed | ~raw;
            r_cmd   <= w_pulse;
            r_held  <= (w_state_nx != CS_IDLE);
        end
    end

    assign cmd  = r_cmd;
    assign held = r_held;

endmodule
`default_nettype wire

// File: rtl/input_repeat_engine.sv
`default_nettype none
// ============================================================================
// Module      : input_repeat_engine
// Description : N_CH-channel button repeat engine (one-shot / DAS / fast).
//               Define INPUT_REPEAT_OPPOSE_EN for LEFT/RIGHT last-pressed-wins.
// Revision    : 1.0 - initial release
// ============================================================================
module input_repeat_engine
    import input_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_game,
    input  logic [N_CH-1:0]   raw_in,
    input  logic [2*N_CH-1:0] cfg_mode,
    input  logic [CNT_W-1:0]  cfg_das,
    input  logic [CNT_W-1:0]  cfg_arr,
    input  logic [CNT_W-1:0]  cfg_fast,
    output logic [N_CH-1:0]   cmd_out,
    output logic [N_CH-1:0]   held_out
);

`ifdef INPUT_REPEAT_OPPOSE_EN
    logic [1:0]      r_opp_prev, r_opp_armed, w_opp_edge;
    logic [N_CH-1:0] w_suppress, w_restart;

    // mirrors the channels' own accepted-press detection for the pair
    always_comb begin
        w_opp_edge = '0;
        for (int k = 0; k < 2; k++) begin
            w_opp_edge[k] = raw_in[k] & ~r_opp_prev[k] & r_opp_armed[k]
                          & (cfg_mode[2*k +: 2] != IM_OFF);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opp_prev  <= '0;
            r_opp_armed <= '0;
        end else begin
            r_opp_prev  <= raw_in[1:0];
            r_opp_armed <= r_opp_armed | ~raw_in[1:0];
        end
    end

    // channel 0 wins a simultaneous press
    assign w_suppress = {{(N_CH-2){1'b0}}, w_opp_edge[0], w_opp_edge[1] & ~w_opp_edge[0]};
    assign w_restart  = {{(N_CH-2){1'b0}}, ~raw_in[0], ~raw_in[1]};
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        input_repeat_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick     (tick_game),
            .raw      (raw_in[i]),
            .mode     (mode_e'(cfg_mode[2*i +: 2])),
            .das      (cfg_das),
            .arr      (cfg_arr),
            .fast     (cfg_fast),
`ifdef INPUT_REPEAT_OPPOSE_EN
            .suppress (w_suppress[i]),
            .restart  (w_restart[i]),
`endif
            .cmd      (cmd_out[i]),
            .held     (held_out[i])
        );
    end

endmodule
`default_nettype wire
